// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: imem-side push channel, decoder-side pop channel,
// branch-redirect flush and occupancy.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int W     = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_ins1;
    logic [W-1:0]  in_ins2;
    logic [W-1:0]  in_pc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_ins1;
    logic [W-1:0]  out_ins2;
    logic [W-1:0]  out_pc;
    logic [CW-1:0] count;

    modport master (
        output flush, in_valid, in_ins1, in_ins2, in_pc, out_ready,
        input  in_ready, out_valid, out_ins1, out_ins2, out_pc, count
    );

    modport slave (
        input  flush, in_valid, in_ins1, in_ins2, in_pc, out_ready,
        output in_ready, out_valid, out_ins1, out_ins2, out_pc, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-pair FIFO between imem and the dual-issue decoder; ready signals
// come only from registered occupancy, and a flush discards every bundle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] ins2;
        logic [W-1:0] ins1;
    } bundle_t;

    bundle_t       mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    assign q.in_ready  = (count_q != CW'(DEPTH));
    assign q.out_valid = (count_q != '0);
    assign q.count     = count_q;
    assign push        = q.in_valid && q.in_ready;
    assign pop         = q.out_valid && q.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else if (q.flush) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // NOTE: the array has no reset; empty slots are masked by out_valid below.
    always_ff @(posedge clk) begin
        if (push && !q.flush) mem[wp] <= '{pc: q.in_pc, ins2: q.in_ins2, ins1: q.in_ins1};
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        q.out_ins1 = '0;
        q.out_ins2 = '0;
        q.out_pc   = '0;
        if (q.out_valid) begin
            q.out_ins1 = mem[rp].ins1;
            q.out_ins2 = mem[rp].ins2;
            q.out_pc   = mem[rp].pc;
        end
    end
endmodule
